lock_port_arbiter: RTL and testbench

LOCK_PORT_ARBITER -- requirements
Module: lock_port_arbiter

---
 rtl/lock_pkg.sv | 23 ++
 rtl/rr_arbiter2.sv | 28 ++
 rtl/lock_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_lock_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad-to-lock port arbiter.
// Holds the controller state encoding, result codes and parameter defaults.
package lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_WAIT,
    ST_REPORT,
    ST_HOLD,
    ST_RELOCK,
    ST_LOCKOUT
  } state_t;

  localparam logic [1:0] RES_WRONG   = 2'b00;
  localparam logic [1:0] RES_UNLOCK  = 2'b01;
  localparam logic [1:0] RES_LOCKOUT = 2'b10;
  localparam logic [1:0] RES_REFUSED = 2'b11;

  localparam int DEF_UNLOCK_HOLD = 50;
  localparam int DEF_RESP_WAIT   = 2;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-port round-robin grant: a tie goes to the port not served last.
// The tie-break pointer moves only when the owner commits a grant.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic prio;  // port that wins the next tie

  // NOTE: always_comb assigns a default first so no path leaves grant unassigned (no latch).
  always_comb begin
    grant = req;
    if (req == 2'b11) grant = prio ? 2'b10 : 2'b01;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio <= 1'b0;
    end else if (advance && (grant != 2'b00)) begin
      prio <= grant[0];
    end
  end

endmodule

// File: rtl/lock_port_arbiter.sv
// Serves two keypads onto one code lock: arbitrates, drives the code, samples
// the lock's answer, holds it open, relocks it and refuses requests in lockout.
module lock_port_arbiter
  import lock_pkg::*;
#(
  parameter int UNLOCK_HOLD = DEF_UNLOCK_HOLD,
  parameter int RESP_WAIT   = DEF_RESP_WAIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [3:0] code0,
  input  logic [3:0] code1,
  input  logic       admin_in,
  output logic [1:0] gnt,
  output logic       done,
  output logic [1:0] result,
  output logic       busy,
  output logic       lock_enter,
  output logic [3:0] lock_code,
  output logic       lock_reset,
  output logic       lock_admin,
  input  logic       lock_unlock,
  input  logic       lock_lockout,
  input  logic [2:0] lock_attempts
);

  localparam int HW = $clog2(UNLOCK_HOLD + 1);
  localparam int WW = $clog2(RESP_WAIT + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(UNLOCK_HOLD - 1);
  localparam logic [HW-1:0] HOLD_TC   = HW'(UNLOCK_HOLD);
  localparam logic [WW-1:0] WAIT_LAST = WW'(RESP_WAIT - 1);

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [WW-1:0] wait_cnt;
  logic [1:0]    arb_grant;
  logic          arb_advance;
  logic          unused_attempts;

  assign unused_attempts = ^lock_attempts;

  // The pointer moves on every grant taken: IDLE exit and each refused response.
  assign arb_advance = (state == ST_IDLE) || ((state == ST_LOCKOUT) && !admin_in);

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (arb_advance),
    .grant   (arb_grant)
  );

  // NOTE: every register, including the captured code and counters, is cleared by the async reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      hold_cnt   <= '0;
      wait_cnt   <= '0;
      gnt        <= 2'b00;
      done       <= 1'b0;
      result     <= RES_WRONG;
      busy       <= 1'b0;
      lock_enter <= 1'b0;
      lock_code  <= 4'b0000;
      lock_reset <= 1'b0;
      lock_admin <= 1'b0;
    end else begin
      lock_admin <= admin_in;
      lock_enter <= 1'b0;
      lock_reset <= 1'b0;
      done       <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (req != 2'b00) begin
            state      <= ST_DRIVE;
            busy       <= 1'b1;
            gnt        <= arb_grant;
            lock_code  <= arb_grant[0] ? code0 : code1;
            lock_enter <= 1'b1;
          end
        end

        ST_DRIVE: begin
          state    <= ST_WAIT;
          wait_cnt <= '0;
        end

        ST_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state <= ST_REPORT;
            done  <= 1'b1;
            // Unlock wins if the lock shows both indications.
            if (lock_unlock)       result <= RES_UNLOCK;
            else if (lock_lockout) result <= RES_LOCKOUT;
            else                   result <= RES_WRONG;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_REPORT: begin
          gnt       <= 2'b00;
          lock_code <= 4'b0000;
          case (result)
            RES_UNLOCK: begin
              state    <= ST_HOLD;
              hold_cnt <= '0;
            end
            RES_LOCKOUT: state <= ST_LOCKOUT;
            default: begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          endcase
        end

        ST_HOLD: begin
          if (hold_cnt != HOLD_TC) hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HOLD_LAST) begin
            state      <= ST_RELOCK;
            lock_reset <= 1'b1;
          end
        end

        ST_RELOCK: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end

        ST_LOCKOUT: begin
          gnt <= 2'b00;
          if (admin_in) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (req != 2'b00) begin
            gnt    <= arb_grant;
            done   <= 1'b1;
            result <= RES_REFUSED;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lock_port_arbiter.sv
// Scoreboard bench: expected grant/result and lock codes are queued as stimulus
// is driven and compared by a monitor when done / lock_enter appear.
module tb_lock_port_arbiter;

  localparam int HOLD  = 50;
  localparam int WAITC = 2;

  typedef struct packed {
    logic [1:0] gnt;
    logic [1:0] res;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [3:0] code0, code1;
  logic       admin_in;
  logic [1:0] gnt;
  logic       done;
  logic [1:0] result;
  logic       busy;
  logic       lock_enter;
  logic [3:0] lock_code;
  logic       lock_reset;
  logic       lock_admin;
  logic       lock_unlock;
  logic       lock_lockout;
  logic [2:0] lock_attempts;

  exp_t       exp_q[$];
  logic [3:0] code_q[$];
  int         n_vec = 0;
  int         n_err = 0;

  lock_port_arbiter #(.UNLOCK_HOLD(HOLD), .RESP_WAIT(WAITC)) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .code0         (code0),
    .code1         (code1),
    .admin_in      (admin_in),
    .gnt           (gnt),
    .done          (done),
    .result        (result),
    .busy          (busy),
    .lock_enter    (lock_enter),
    .lock_code     (lock_code),
    .lock_reset    (lock_reset),
    .lock_admin    (lock_admin),
    .lock_unlock   (lock_unlock),
    .lock_lockout  (lock_lockout),
    .lock_attempts (lock_attempts)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      if (done) begin
        if (exp_q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_gnt", gnt, e.gnt);
          check("sb_result", result, e.res);
        end
      end
      if (lock_enter) begin
        if (code_q.size() == 0) check("enter_unexpected", 1, 0);
        else check("sb_lock_code", lock_code, code_q.pop_front());
      end
      if (lock_enter || lock_reset || done)
        check("pulse_exclusive", int'(lock_enter) + int'(lock_reset) + int'(done), 1);
    end
  end

  task automatic wait_enter();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lock_enter && n < 50);
    check("enter_seen", lock_enter, 1);
  endtask

  task automatic run_txn(input int port, input logic [3:0] code, input logic unl,
                         input logic lko, input logic [1:0] exp_res);
    logic [1:0] g;
    exp_t       e;
    int         n;
    g = (port == 0) ? 2'b01 : 2'b10;
    @(posedge clk); #1;
    if (port == 0) code0 = code; else code1 = code;
    req = g;
    lock_unlock  = unl;
    lock_lockout = lko;
    e.gnt = g;
    e.res = exp_res;
    exp_q.push_back(e);
    code_q.push_back(code);
    wait_enter();
    req = 2'b00;  // dropping the request in DRIVE must not abort
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("gnt_hold", gnt, g);
        check("code_hold", lock_code, code);
      end
    end while (!done && n < 20);
    check("done_latency", n, WAITC + 1);
    lock_unlock  = 1'b0;
    lock_lockout = 1'b0;
  endtask

  task automatic check_hold();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lock_reset && n < HOLD + 20);
    check("hold_len", n, HOLD + 1);
    check("busy_in_relock", busy, 1);
    @(negedge clk);
    check("idle_after_relock", busy, 0);
    check("relock_single", lock_reset, 0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("sb_drain", exp_q.size(), 0);
  endtask

  initial begin
    exp_t e;
    int   n;
    reset = 1'b1;
    req = 2'b00; code0 = 4'h0; code1 = 4'h0; admin_in = 1'b0;
    lock_unlock = 1'b0; lock_lockout = 1'b0; lock_attempts = 3'b000;
    #2 reset = 1'b0;
    #2;
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_lock_code", lock_code, 0);
    @(negedge clk);
    reset = 1'b1;

    // Wrong code on port 0, lock stays locked.
    run_txn(0, 4'b0001, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    check("idle_after_wrong", busy, 0);

    // Correct code: unlock, hold, relock.
    run_txn(0, 4'b1010, 1'b1, 1'b0, 2'b01);
    check_hold();

    // Both indications high: unlock wins.
    run_txn(1, 4'b0110, 1'b1, 1'b1, 2'b01);
    check_hold();

    // Lockout, refused request, admin clear.
    run_txn(0, 4'b0111, 1'b0, 1'b1, 2'b10);
    @(negedge clk);
    check("in_lockout", busy, 1);
    @(posedge clk); #1;
    req = 2'b10;
    e.gnt = 2'b10;
    e.res = 2'b11;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    check("refused_done", done, 1);
    req = 2'b00;
    @(negedge clk);
    check("refused_single", done, 0);
    check("still_lockout", busy, 1);
    @(posedge clk); #1;
    admin_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("admin_fwd", lock_admin, 1);
    check("admin_to_idle", busy, 0);
    admin_in = 1'b0;
    @(negedge clk);
    check("admin_fwd_low", lock_admin, 0);

    // Reset in WAIT on a port-0 transaction: not reported, pointer back to port 0.
    @(posedge clk); #1;
    code0 = 4'b1001;
    req = 2'b01;
    lock_unlock = 1'b1;
    code_q.push_back(4'b1001);
    wait_enter();
    req = 2'b00;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("wrst_gnt", gnt, 0);
    check("wrst_done", done, 0);
    check("wrst_result", result, 0);
    check("wrst_busy", busy, 0);
    check("wrst_enter", lock_enter, 0);
    check("wrst_code", lock_code, 0);
    check("wrst_relock", lock_reset, 0);
    check("wrst_admin", lock_admin, 0);
    @(negedge clk);
    reset = 1'b1;
    lock_unlock = 1'b0;
    repeat (5) @(negedge clk);
    check("wrst_idle", busy, 0);

    // Tie with req=11 held: grants alternate 01, 10, 01.
    @(posedge clk); #1;
    code0 = 4'b0011;
    code1 = 4'b0101;
    req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      e.gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
      e.res = 2'b00;
      exp_q.push_back(e);
      code_q.push_back((i % 2 == 0) ? 4'b0011 : 4'b0101);
    end
    for (int i = 0; i < 3; i++) begin
      wait_enter();
      if (i == 2) req = 2'b00;
    end
    drain();
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("final_idle", busy, 0);
    check("code_q_empty", code_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
